// File: rtl/spi_cmd_rx_if.sv
// Packet-side interface of spi_cmd_rx: FWFT packet stream plus status/control.
// The receiver drives through the master modport; the consumer uses slave.
interface spi_cmd_rx_if #(
  parameter int PKT_BYTES  = 2,
  parameter int FIFO_DEPTH = 4
);
  logic [8*PKT_BYTES-1:0]      pkt_data;
  logic                        pkt_valid;
  logic                        pkt_ready;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        overflow;
  logic                        frame_err;
  logic                        clear_ovf;

  modport master (
    output pkt_data, pkt_valid, fifo_level, overflow, frame_err,
    input  pkt_ready, clear_ovf
  );

  modport slave (
    input  pkt_data, pkt_valid, fifo_level, overflow, frame_err,
    output pkt_ready, clear_ovf
  );
endinterface

// File: rtl/spi_cmd_rx.sv
// SPI command receiver: synchronizes an MCU-driven SPI link into clk, assembles
// fixed-length MSB-first packets and queues them in a first-word-fall-through FIFO.
module spi_cmd_rx #(
  parameter int PKT_BYTES   = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sck,
  input  logic         sdi,
  input  logic         cs,
  spi_cmd_rx_if.master pkt
);
  localparam int W  = 8 * PKT_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(W + 1);
  localparam logic [LW-1:0] DEPTH    = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, cs_sync;
  logic                   sck_prev;
  logic                   sck_s, sdi_s, cs_s, sck_rise;

  state_t          state, state_next;
  logic [W-1:0]    shift_q;
  logic [CW-1:0]   bit_cnt;
  logic            push_req, frame_err_c;

  logic [W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            full, pop, push, ovf_set, overflow_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync <= '0;
      sdi_sync <= '0;
      cs_sync  <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_prev <= sck_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_next  = state;
    push_req    = 1'b0;
    frame_err_c = 1'b0;
    case (state)
      IDLE: if (cs_s) state_next = RECV;
      RECV: if (!cs_s) state_next = DONE;
      DONE: begin
        state_next = IDLE;
        if (bit_cnt == CNT_FULL) push_req    = 1'b1;
        else                     frame_err_c = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding the shifter clear throughout IDLE gives a clean start on RECV entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (state == IDLE) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (state == RECV && sck_rise) begin
      shift_q <= {shift_q[W-2:0], sdi_s};
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CW'(1);
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign full    = (level == DEPTH);
  assign pop     = (level != '0) && pkt.pkt_ready;
  assign push    = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  // NOTE: packet storage has no reset; pkt_data is gated by pkt_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (ovf_set)            overflow_q <= 1'b1;
      else if (pkt.clear_ovf) overflow_q <= 1'b0;
    end
  end

  assign pkt.pkt_valid  = (level != '0);
  assign pkt.pkt_data   = pkt.pkt_valid ? mem[rd_ptr] : '0;
  assign pkt.fifo_level = level;
  assign pkt.overflow   = overflow_q;
  assign pkt.frame_err  = frame_err_c;
endmodule

// File: tb/tb_spi_cmd_rx.sv
// Self-checking bench for spi_cmd_rx: directed scenarios plus a random phase,
// compared against a packet-queue reference model of the receiver.
module tb_spi_cmd_rx;
  logic clk = 1'b0;
  logic reset_n;
  logic sck, sdi, cs, cs2;

  int checks = 0;
  int errors = 0;

  spi_cmd_rx_if #(.PKT_BYTES(2), .FIFO_DEPTH(4)) pif ();
  spi_cmd_rx_if #(.PKT_BYTES(3), .FIFO_DEPTH(2)) pif2 ();

  spi_cmd_rx #(.PKT_BYTES(2), .FIFO_DEPTH(4), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .cs(cs), .pkt(pif.master));

  spi_cmd_rx #(.PKT_BYTES(3), .FIFO_DEPTH(2), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .cs(cs2), .pkt(pif2.master));

  always #5 clk = ~clk;

  // Reference model: one packet queue, overflow flag and frame_err count per instance.
  logic [63:0] q  [$];
  logic [63:0] q2 [$];
  logic        ovf_m  = 1'b0;
  logic        ovf2_m = 1'b0;
  int          ferr_exp = 0, ferr2_exp = 0;
  int          ferr_cnt = 0, ferr2_cnt = 0;

  always @(posedge clk) begin
    if (pif.frame_err)  ferr_cnt  <= ferr_cnt + 1;
    if (pif2.frame_err) ferr2_cnt <= ferr2_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [63:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = data[i];
      tick(4);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic set_cs(input int sel, input logic v);
    if (sel == 0) cs = v;
    else          cs2 = v;
  endtask

  task automatic model_frame(input int sel, input logic [63:0] data, input int n);
    if (sel == 0) begin
      if (n != 16)          ferr_exp++;
      else if (q.size() < 4) q.push_back(64'(data[15:0]));
      else                   ovf_m = 1'b1;
    end else begin
      if (n != 24)            ferr2_exp++;
      else if (q2.size() < 2) q2.push_back(64'(data[23:0]));
      else                    ovf2_m = 1'b1;
    end
  endtask

  task automatic frame(input int sel, input logic [63:0] data, input int n);
    set_cs(sel, 1'b1);
    tick(6);
    send_bits(data, n);
    tick(2);
    set_cs(sel, 1'b0);
    tick(8);
    model_frame(sel, data, n);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".level"}, 64'(pif.fifo_level), 64'(q.size()));
    check({tag, ".valid"}, 64'(pif.pkt_valid), 64'(q.size() != 0));
    check({tag, ".data"},  64'(pif.pkt_data),  (q.size() != 0) ? q[0] : 64'd0);
    check({tag, ".ovf"},   64'(pif.overflow),  64'(ovf_m));
    check({tag, ".ferr"},  64'(ferr_cnt),      64'(ferr_exp));
  endtask

  task automatic check_state2(input string tag);
    check({tag, ".level2"}, 64'(pif2.fifo_level), 64'(q2.size()));
    check({tag, ".valid2"}, 64'(pif2.pkt_valid),  64'(q2.size() != 0));
    check({tag, ".data2"},  64'(pif2.pkt_data),   (q2.size() != 0) ? q2[0] : 64'd0);
    check({tag, ".ovf2"},   64'(pif2.overflow),   64'(ovf2_m));
    check({tag, ".ferr2"},  64'(ferr2_cnt),       64'(ferr2_exp));
  endtask

  // Pops one packet (or attempts a pop on an empty FIFO, which must be ignored).
  task automatic pop(input int sel, input string tag);
    if (sel == 0) begin
      if (q.size() != 0) check({tag, ".pop_data"}, 64'(pif.pkt_data), q[0]);
      pif.pkt_ready = 1'b1;
      tick(1);
      pif.pkt_ready = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
    end else begin
      if (q2.size() != 0) check({tag, ".pop_data2"}, 64'(pif2.pkt_data), q2[0]);
      pif2.pkt_ready = 1'b1;
      tick(1);
      pif2.pkt_ready = 1'b0;
      if (q2.size() != 0) void'(q2.pop_front());
    end
  endtask

  task automatic clear_ovf(input int sel);
    if (sel == 0) begin pif.clear_ovf  = 1'b1; tick(1); pif.clear_ovf  = 1'b0; ovf_m  = 1'b0; end
    else          begin pif2.clear_ovf = 1'b1; tick(1); pif2.clear_ovf = 1'b0; ovf2_m = 1'b0; end
  endtask

  initial begin
    int lat;
    int nb;
    int nbits_tab [7] = '{16, 16, 16, 0, 15, 17, 9};
    logic [63:0] d;

    reset_n = 1'b0; sck = 1'b0; sdi = 1'b0; cs = 1'b0; cs2 = 1'b0;
    pif.pkt_ready = 1'b0;  pif.clear_ovf = 1'b0;
    pif2.pkt_ready = 1'b0; pif2.clear_ovf = 1'b0;
    tick(3);
    check_state("reset");
    check_state2("reset");
    check("reset.frame_err", 64'(pif.frame_err), 64'd0);
    reset_n = 1'b1;
    tick(2);

    // Single 16-bit frame: valid one cycle after DONE, i.e. 4 edges after cs drops.
    cs = 1'b1;
    tick(6);
    send_bits(64'hA53C, 16);
    tick(2);
    cs = 1'b0;
    lat = 0;
    while (!pif.pkt_valid && lat <= 20) begin
      tick(1);
      lat++;
    end
    check("a53c.latency", 64'(lat), 64'd4);
    model_frame(0, 64'hA53C, 16);
    tick(4);
    check_state("a53c");
    check("a53c.const", 64'(pif.pkt_data), 64'hA53C);
    pop(0, "a53c");
    check_state("a53c_drained");

    // Five frames into a 4-deep FIFO: fifth overflows, order preserved.
    for (int i = 1; i <= 5; i++) begin
      frame(0, 64'(i), 16);
      check_state($sformatf("fill%0d", i));
    end
    check("fill.ovf_set", 64'(pif.overflow), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d.const", i), 64'(pif.pkt_data), 64'(i));
      pop(0, "drain");
    end
    check_state("drained");
    clear_ovf(0);
    check_state("ovf_cleared");

    // Wrong bit counts: 15, 17, and an empty frame.
    frame(0, 64'h7ABC, 15);
    check_state("bits15");
    frame(0, 64'h1F00D, 17);
    check_state("bits17");
    frame(0, 64'h0, 0);
    check_state("bits0");

    // Full FIFO with a pop in the DONE cycle of a new frame: push accepted, no overflow.
    for (int i = 0; i < 4; i++) frame(0, 64'h1111 * (i + 1), 16);
    check_state("full");
    cs = 1'b1;
    tick(6);
    send_bits(64'h1234, 16);
    tick(2);
    cs = 1'b0;
    tick(3);
    check("donepop.data", 64'(pif.pkt_data), q[0]);
    pif.pkt_ready = 1'b1;
    tick(1);
    pif.pkt_ready = 1'b0;
    void'(q.pop_front());
    q.push_back(64'h1234);
    tick(4);
    check_state("donepop");
    for (int i = 0; i < 3; i++) pop(0, "donepop_drain");
    check("donepop.last", 64'(pif.pkt_data), 64'h1234);
    pop(0, "donepop_last");
    check_state("donepop_empty");

    // Reset mid-frame with cs held high: remaining bits form a short frame.
    frame(0, 64'hBEEF, 16);
    cs = 1'b1;
    tick(6);
    send_bits(64'hA5, 8);
    reset_n = 1'b0;
    q.delete(); ovf_m = 1'b0;
    q2.delete(); ovf2_m = 1'b0;
    tick(1);
    check_state("in_reset");
    tick(1);
    reset_n = 1'b1;
    tick(6);
    send_bits(64'h5A, 8);
    tick(2);
    cs = 1'b0;
    tick(8);
    ferr_exp++;
    check_state("reset_midframe");

    // Random frames, pops, empty pops and overflow clears.
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          nb = nbits_tab[$urandom_range(0, 6)];
          d  = {$urandom, $urandom};
          frame(0, d, nb);
        end
        2:       pop(0, "rand");
        default: clear_ovf(0);
      endcase
      tick(2);
      check_state($sformatf("rand%0d", it));
    end

    // 3-byte packets, 2-deep FIFO; overflow set wins over a same-cycle clear.
    frame(1, 64'hDEADBE, 24);
    check_state2("deadbe");
    check("deadbe.const", 64'(pif2.pkt_data), 64'hDEADBE);
    frame(1, 64'h010203, 24);
    check_state2("full2");
    cs2 = 1'b1;
    tick(6);
    send_bits(64'hC0FFEE, 24);
    tick(2);
    cs2 = 1'b0;
    tick(3);
    pif2.clear_ovf = 1'b1;
    tick(1);
    pif2.clear_ovf = 1'b0;
    ovf2_m = 1'b1;
    check("set_wins.ovf2", 64'(pif2.overflow), 64'd1);
    tick(4);
    check_state2("set_wins");
    clear_ovf(1);
    check_state2("ovf2_cleared");
    pop(1, "p2a");
    pop(1, "p2b");
    check_state2("p2_empty");
    check_state("inst1_untouched");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
